ring_phase_deserializer: RTL and testbench
==========================================

Name: ring_phase_deserializer

Overview:
- Downstream consumer of the n-bit one-hot ring counter.
- Samples a narrow data lane once per ring phase and assembles one wide word per full ring revolution.
- Presents each word on a valid/ready output with a one-entry buffer.
- Checks ring integrity (one-hot, correct rotation order) and flags sticky error and overrun conditions.

Parameters:
- WIDTH, 4: number of ring phases and number of lane slots per word; must be >= 2; must match the ring counter.
- DATA_W, 8: lane width in bits.
- CNT_W, 8: width of the delivered-word counter.

Ports:
- clk_i  input  1  clock; all logic on the rising edge.
- rst_i  input  1  reset, synchronous, active-high.
- phase_i  input  WIDTH  one-hot phase vector from the ring counter.
- lane_i  input  DATA_W  data captured in the active phase's slot.
- ready_i  input  1  downstream accepts word_o when valid_o && ready_i.
- err_clr_i  input  1  clears err_o and overrun_o.
- word_o  output  WIDTH*DATA_W  assembled word; slot k at [k*DATA_W +: DATA_W].
- valid_o  output  1  word_o holds an unconsumed word.
- err_o  output  1  sticky ring-integrity error.
- overrun_o  output  1  sticky: completed word dropped because the buffer was full.
- words_o  output  CNT_W  count of words loaded into the output buffer; wraps modulo 2^CNT_W.

Behaviour:
- Reset: clk_i and rst_i follow the codebase naming; reset is synchronous, active-high.
  - rst_i=1 at an edge zeroes word_o, valid_o, err_o, overrun_o, words_o, the assembly register and the stored previous phase.
  - State goes to S_SYNC.
  - Reset mid-word or with valid_o=1 discards everything; no handshake completes that cycle.
- Legal phase: exactly one bit set. Expected next phase = rotl(prev) = {prev[WIDTH-2:0], prev[WIDTH-1]}.
- S_SYNC:
  - Illegal phase_i (zero or multi-hot): set err_o.
  - Legal phase_i != bit0: wait, no capture, no error.
  - phase_i == bit0: capture lane_i into slot 0, prev<=phase_i, go to S_RUN.
- S_RUN, evaluated in priority order:
  - Illegal phase_i: set err_o, discard the partial word, go to S_SYNC.
  - phase_i == prev: hold; no capture. This tolerates an enabled or stalled ring.
  - phase_i == rotl(prev): capture lane_i into slot log2(phase_i); prev<=phase_i.
  - Any other legal value (skip or reverse): set err_o, discard the partial word, go to S_SYNC.
  - A bit0 capture after a completed word starts the next word directly; no SYNC pass is needed.
- Completion:
  - Capture in slot WIDTH-1 completes the word.
  - The completed word, with the lane_i value merged in, loads into the output buffer on the same edge if !valid_o or (valid_o && ready_i).
  - Latency: valid_o=1 and word_o valid in the cycle after phase_i[WIDTH-1] is sampled; words_o increments on the same edge.
  - Buffer full and not being consumed: drop the new word, keep word_o unchanged, set overrun_o.
- Handshake:
  - word_o is stable while valid_o=1 && ready_i=0.
  - valid_o falls on the edge after the handshake unless a new word loads on the same edge.
  - No combinational path from ready_i to any output.
- Sticky flags: err_clr_i clears err_o and overrun_o. If a set event coincides with err_clr_i, the set wins.
- Slots of a partially assembled word are never visible on word_o.

Decomposition:
- Package ring_pkg:
  - state typedef enum {S_SYNC, S_RUN}.
  - Function rotl_onehot(vec).
  - Function onehot_to_idx(vec).
- One natural sub-module: ring_onehot_check. Combinational; outputs is_onehot and idx for phase_i. It can be reused by other ring consumers.

Test Plan (WIDTH=4, DATA_W=8):
- Clean revolution: reset, then phase_i 0001/0010/0100/1000 with lane_i 11/22/33/44h, ready_i=1 -> cycle after the 1000 sample: valid_o=1, word_o=32'h44332211, words_o=1, err_o=0.
- Hold: 0001, 0010 for 3 cycles (lane_i 22h, 99h, AAh), 0100, 1000 -> word_o slot1=22h; no error.
- Backpressure: ready_i=0 across two revolutions (11..44h, then 55..88h) -> word_o stays 44332211h, overrun_o=1, words_o=1. Raise ready_i for 1 cycle -> valid_o=0 next cycle.
- Illegal phase: 0001, 0110 -> err_o=1 next cycle, partial discarded. Then 0100 gives no capture. Then 0001..1000 -> valid word. Pulse err_clr_i -> err_o=0.
- Skip: 0001 then 0100 -> err_o=1, return to S_SYNC. Simultaneous err_clr_i with a new illegal phase -> err_o stays 1.
- Reset mid-operation: valid_o=1 and slots 0-1 captured, assert rst_i -> next cycle all outputs 0. The next 0001..1000 produces words_o=1.

Source files
------------

// File: rtl/ring_pkg.sv
// Shared types and helpers for consumers of the one-hot ring counter.
// Latency: none; this package holds only types and pure functions.
// Backpressure: not applicable.
package ring_pkg;

  // Upper bound on ring width handled by the helper functions below.
  localparam int MAX_W = 64;

  typedef enum logic [0:0] {
    S_SYNC = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  // Rotate the low w bits of vec left by one; bits at or above w stay zero.
  function automatic logic [MAX_W-1:0] rotl_onehot(input logic [MAX_W-1:0] vec, input int w);
    logic [MAX_W-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_W; i++) begin
      if (i == w - 1) begin
        r[0] = vec[i];
      end else if (i < w - 1) begin
        r[i+1] = vec[i];
      end
    end
    return r;
  endfunction

  // Position of the highest set bit; for a one-hot input, its only set bit.
  function automatic int onehot_to_idx(input logic [MAX_W-1:0] vec);
    int idx;
    idx = 0;
    for (int i = 0; i < MAX_W; i++) begin
      if (vec[i]) begin
        idx = i;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/ring_onehot_check.sv
// Classifies a ring phase vector: one-hot legality plus the active slot index.
// Latency: purely combinational.
// Backpressure: none; the result follows phase_i continuously.
module ring_onehot_check
  import ring_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] phase_i,
  output logic             is_onehot,
  output logic [IDX_W-1:0] idx
);

  // A vector is one-hot when it is non-zero and clearing its lowest set bit leaves nothing.
  always_comb begin
    is_onehot = (phase_i != '0) && ((phase_i & (phase_i - 1'b1)) == '0);
    idx       = IDX_W'(onehot_to_idx(MAX_W'(phase_i)));
  end

endmodule

// File: rtl/ring_phase_deserializer.sv
// Assembles one WIDTH-slot word per ring revolution and checks ring integrity.
// Latency: the word appears on word_o/valid_o one cycle after the last phase is sampled.
// Backpressure: one-entry output buffer; a completed word that finds it full is dropped and flagged as overrun.
module ring_phase_deserializer
  import ring_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [WIDTH-1:0]        phase_i,
  input  logic [DATA_W-1:0]       lane_i,
  input  logic                    ready_i,
  input  logic                    err_clr_i,
  output logic [WIDTH*DATA_W-1:0] word_o,
  output logic                    valid_o,
  output logic                    err_o,
  output logic                    overrun_o,
  output logic [CNT_W-1:0]        words_o
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t                  state_q, state_d;
  logic [WIDTH-1:0]        prev_q;
  logic [WIDTH*DATA_W-1:0] asm_q, asm_d;
  logic                    is_onehot;
  logic [IDX_W-1:0]        idx;
  logic [WIDTH-1:0]        rot_prev;
  logic                    capture, ring_err, complete, load, drop;

  ring_onehot_check #(
    .WIDTH (WIDTH),
    .IDX_W (IDX_W)
  ) u_check (
    .phase_i   (phase_i),
    .is_onehot (is_onehot),
    .idx       (idx)
  );

  assign rot_prev = WIDTH'(rotl_onehot(MAX_W'(prev_q), WIDTH));

  // Decide capture/error/next state from the sampled phase and the last accepted phase.
  always_comb begin
    capture  = 1'b0;
    ring_err = 1'b0;
    state_d  = state_q;
    case (state_q)
      S_SYNC: begin
        if (!is_onehot) begin
          ring_err = 1'b1;
        end else if (phase_i[0]) begin
          capture = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (!is_onehot) begin
          ring_err = 1'b1;
          state_d  = S_SYNC;
        end else if (phase_i == prev_q) begin
          // Stalled ring: hold without capturing.
        end else if (phase_i == rot_prev) begin
          capture = 1'b1;
        end else begin
          ring_err = 1'b1;
          state_d  = S_SYNC;
        end
      end
      default: state_d = S_SYNC;
    endcase
  end

  // Merge the current lane into its slot so a completing word can load in the same edge.
  always_comb begin
    asm_d = asm_q;
    asm_d[idx*DATA_W +: DATA_W] = lane_i;
  end

  assign complete = capture && phase_i[WIDTH-1];
  assign load     = complete && (!valid_o || ready_i);
  assign drop     = complete && valid_o && !ready_i;

  // Ring tracking: FSM state, last accepted phase and the partial word.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_SYNC;
      prev_q  <= '0;
      asm_q   <= '0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        prev_q <= phase_i;
        asm_q  <= asm_d;
      end else if (ring_err) begin
        asm_q <= '0;
      end
    end
  end

  // Output buffer: load a completed word, otherwise release it on handshake.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      word_o  <= '0;
      valid_o <= 1'b0;
      words_o <= '0;
    end else if (load) begin
      word_o  <= asm_d;
      valid_o <= 1'b1;
      words_o <= words_o + 1'b1;
    end else if (valid_o && ready_i) begin
      valid_o <= 1'b0;
    end
  end

  // Sticky flags; a new set event takes priority over a clear in the same cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_o     <= 1'b0;
      overrun_o <= 1'b0;
    end else begin
      if (ring_err)       err_o <= 1'b1;
      else if (err_clr_i) err_o <= 1'b0;
      if (drop)           overrun_o <= 1'b1;
      else if (err_clr_i) overrun_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ring_phase_deserializer.sv
// Bench for ring_phase_deserializer: directed vector table, a reset sequence, then random traffic vs a model.
// Latency: outputs are checked 1 time unit after each rising edge.
// Backpressure: ready_i is driven from the table or randomly.
module tb_ring_phase_deserializer;

  localparam int W  = 4;
  localparam int DW = 8;
  localparam int CW = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [W-1:0]    phase = '0;
  logic [DW-1:0]   lane = '0;
  logic            ready = 1'b0;
  logic            err_clr = 1'b0;
  logic [W*DW-1:0] word;
  logic            valid, err, overrun;
  logic [CW-1:0]   words;

  int n_vec = 0;
  int n_bad = 0;

  ring_phase_deserializer #(.WIDTH(W), .DATA_W(DW), .CNT_W(CW)) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .phase_i   (phase),
    .lane_i    (lane),
    .ready_i   (ready),
    .err_clr_i (err_clr),
    .word_o    (word),
    .valid_o   (valid),
    .err_o     (err),
    .overrun_o (overrun),
    .words_o   (words)
  );

  always #5 clk = ~clk;

  // Reference model: slot-level view of the ring and a one-entry buffer.
  bit              m_synced = 0;
  int              m_last = 0;
  logic [DW-1:0]   m_slots [W];
  logic            m_bvalid = 0, m_err = 0, m_ovr = 0;
  logic [W*DW-1:0] m_bword = '0;
  logic [CW-1:0]   m_cnt = '0;

  task automatic model_update();
    bit set_err, set_ovr, done, legal;
    int pidx;
    if (rst) begin
      m_synced = 0; m_last = 0; m_bvalid = 0; m_err = 0; m_ovr = 0;
      m_bword = '0; m_cnt = '0;
      for (int k = 0; k < W; k++) m_slots[k] = '0;
      return;
    end
    set_err = 0; set_ovr = 0; done = 0;
    legal = ($countones(phase) == 1);
    pidx = 0;
    for (int k = 0; k < W; k++) if (phase[k]) pidx = k;
    if (!m_synced) begin
      if (!legal) set_err = 1;
      else if (pidx == 0) begin m_slots[0] = lane; m_synced = 1; m_last = 0; end
    end else if (!legal) begin
      set_err = 1; m_synced = 0;
    end else if (pidx == m_last) begin
      set_err = 0;
    end else if (pidx == (m_last + 1) % W) begin
      m_slots[pidx] = lane; m_last = pidx; done = (pidx == W - 1);
    end else begin
      set_err = 1; m_synced = 0;
    end
    if (done) begin
      if (!m_bvalid || ready) begin
        for (int k = 0; k < W; k++) m_bword[k*DW +: DW] = m_slots[k];
        m_bvalid = 1; m_cnt = m_cnt + 1'b1;
      end else set_ovr = 1;
    end else if (m_bvalid && ready) m_bvalid = 0;
    if (set_err) m_err = 1; else if (err_clr) m_err = 0;
    if (set_ovr) m_ovr = 1; else if (err_clr) m_ovr = 0;
  endtask

  task automatic apply(input logic r, input logic [W-1:0] ph, input logic [DW-1:0] ln,
                       input logic rdy, input logic clr);
    rst = r; phase = ph; lane = ln; ready = rdy; err_clr = clr;
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic chk(input string name, input logic [42:0] exp);
    logic [42:0] got;
    got = {valid, word, err, overrun, words};
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got v=%0b word=%h err=%0b ovr=%0b words=%0d, expected v=%0b word=%h err=%0b ovr=%0b words=%0d",
               name, got[42], got[41:10], got[9], got[8], got[7:0],
               exp[42], exp[41:10], exp[9], exp[8], exp[7:0]);
    end
  endtask

  typedef struct {
    logic          rst;
    logic [W-1:0]  ph;
    logic [DW-1:0] ln;
    logic          rdy;
    logic          clr;
    logic          e_v;
    logic [31:0]   e_word;
    logic          e_err;
    logic          e_ovr;
    logic [7:0]    e_cnt;
  } vec_t;

  function automatic vec_t mk(logic r, logic [3:0] ph, logic [7:0] ln, logic rdy, logic clr,
                              logic v, logic [31:0] w, logic e, logic o, logic [7:0] c);
    vec_t t;
    t.rst = r; t.ph = ph; t.ln = ln; t.rdy = rdy; t.clr = clr;
    t.e_v = v; t.e_word = w; t.e_err = e; t.e_ovr = o; t.e_cnt = c;
    return t;
  endfunction

  initial begin
    vec_t tbl[$];
    int   rp;
    logic [W-1:0] ph;

    // Clean revolution.
    tbl.push_back(mk(1, 4'b0000, 8'h00, 1, 0, 0, 32'h0, 0, 0, 0));
    tbl.push_back(mk(0, 4'b0001, 8'h11, 1, 0, 0, 32'h0, 0, 0, 0));
    tbl.push_back(mk(0, 4'b0010, 8'h22, 1, 0, 0, 32'h0, 0, 0, 0));
    tbl.push_back(mk(0, 4'b0100, 8'h33, 1, 0, 0, 32'h0, 0, 0, 0));
    tbl.push_back(mk(0, 4'b1000, 8'h44, 1, 0, 1, 32'h44332211, 0, 0, 1));
    // Held phase: only the first sample of slot 1 counts.
    tbl.push_back(mk(0, 4'b0001, 8'h55, 1, 0, 0, 32'h44332211, 0, 0, 1));
    tbl.push_back(mk(0, 4'b0010, 8'h22, 1, 0, 0, 32'h44332211, 0, 0, 1));
    tbl.push_back(mk(0, 4'b0010, 8'h99, 1, 0, 0, 32'h44332211, 0, 0, 1));
    tbl.push_back(mk(0, 4'b0010, 8'hAA, 1, 0, 0, 32'h44332211, 0, 0, 1));
    tbl.push_back(mk(0, 4'b0100, 8'h33, 1, 0, 0, 32'h44332211, 0, 0, 1));
    tbl.push_back(mk(0, 4'b1000, 8'h44, 1, 0, 1, 32'h44332255, 0, 0, 2));
    // Backpressure across two revolutions.
    tbl.push_back(mk(1, 4'b0000, 8'h00, 0, 0, 0, 32'h0, 0, 0, 0));
    tbl.push_back(mk(0, 4'b0001, 8'h11, 0, 0, 0, 32'h0, 0, 0, 0));
    tbl.push_back(mk(0, 4'b0010, 8'h22, 0, 0, 0, 32'h0, 0, 0, 0));
    tbl.push_back(mk(0, 4'b0100, 8'h33, 0, 0, 0, 32'h0, 0, 0, 0));
    tbl.push_back(mk(0, 4'b1000, 8'h44, 0, 0, 1, 32'h44332211, 0, 0, 1));
    tbl.push_back(mk(0, 4'b0001, 8'h55, 0, 0, 1, 32'h44332211, 0, 0, 1));
    tbl.push_back(mk(0, 4'b0010, 8'h66, 0, 0, 1, 32'h44332211, 0, 0, 1));
    tbl.push_back(mk(0, 4'b0100, 8'h77, 0, 0, 1, 32'h44332211, 0, 0, 1));
    tbl.push_back(mk(0, 4'b1000, 8'h88, 0, 0, 1, 32'h44332211, 0, 1, 1));
    tbl.push_back(mk(0, 4'b0001, 8'h00, 1, 0, 0, 32'h44332211, 0, 1, 1));
    tbl.push_back(mk(0, 4'b0001, 8'h00, 0, 0, 0, 32'h44332211, 0, 1, 1));
    tbl.push_back(mk(0, 4'b0001, 8'h01, 1, 1, 0, 32'h44332211, 0, 0, 1));
    // Illegal multi-hot phase, then resync.
    tbl.push_back(mk(0, 4'b0110, 8'h02, 1, 0, 0, 32'h44332211, 1, 0, 1));
    tbl.push_back(mk(0, 4'b0100, 8'h03, 1, 0, 0, 32'h44332211, 1, 0, 1));
    tbl.push_back(mk(0, 4'b0001, 8'hA1, 1, 0, 0, 32'h44332211, 1, 0, 1));
    tbl.push_back(mk(0, 4'b0010, 8'hB2, 1, 0, 0, 32'h44332211, 1, 0, 1));
    tbl.push_back(mk(0, 4'b0100, 8'hC3, 1, 0, 0, 32'h44332211, 1, 0, 1));
    tbl.push_back(mk(0, 4'b1000, 8'hD4, 1, 0, 1, 32'hD4C3B2A1, 1, 0, 2));
    tbl.push_back(mk(0, 4'b0001, 8'h00, 1, 1, 0, 32'hD4C3B2A1, 0, 0, 2));
    // Skip, set-beats-clear, then reverse rotation.
    tbl.push_back(mk(0, 4'b0100, 8'h00, 1, 0, 0, 32'hD4C3B2A1, 1, 0, 2));
    tbl.push_back(mk(0, 4'b0000, 8'h00, 1, 1, 0, 32'hD4C3B2A1, 1, 0, 2));
    tbl.push_back(mk(0, 4'b0001, 8'h00, 1, 1, 0, 32'hD4C3B2A1, 0, 0, 2));
    tbl.push_back(mk(0, 4'b0010, 8'h00, 1, 0, 0, 32'hD4C3B2A1, 0, 0, 2));
    tbl.push_back(mk(0, 4'b0001, 8'h00, 1, 0, 0, 32'hD4C3B2A1, 1, 0, 2));

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i].rst, tbl[i].ph, tbl[i].ln, tbl[i].rdy, tbl[i].clr);
      chk($sformatf("tbl%0d", i),
          {tbl[i].e_v, tbl[i].e_word, tbl[i].e_err, tbl[i].e_ovr, tbl[i].e_cnt});
    end

    // Reset while a word is buffered and another is half assembled.
    apply(0, 4'b0001, 8'h01, 0, 0);
    apply(0, 4'b0010, 8'h02, 0, 0);
    apply(0, 4'b0100, 8'h03, 0, 0);
    apply(0, 4'b1000, 8'h04, 0, 0);
    apply(0, 4'b0001, 8'h11, 0, 0);
    apply(0, 4'b0010, 8'h22, 0, 0);
    chk("pre_rst", {1'b1, 32'h04030201, 1'b1, 1'b0, 8'd3});
    apply(1, 4'b0100, 8'h33, 1, 0);
    chk("mid_rst", {1'b0, 32'h0, 1'b0, 1'b0, 8'd0});
    apply(0, 4'b0001, 8'h11, 0, 0);
    apply(0, 4'b0010, 8'h22, 0, 0);
    apply(0, 4'b0100, 8'h33, 0, 0);
    apply(0, 4'b1000, 8'h44, 0, 0);
    chk("post_rst", {1'b1, 32'h44332211, 1'b0, 1'b0, 8'd1});

    // Random traffic: mostly a well-behaved ring with stalls, plus glitches and resets.
    apply(1, 4'b0000, 8'h00, 0, 0);
    rp = W - 1;
    for (int i = 0; i < 3000; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 60) begin
        rp = (rp + 1) % W;
        ph = 4'b0001 << rp;
      end else if (r < 85) begin
        ph = 4'b0001 << rp;
      end else if (r < 91) begin
        ph = 4'($urandom_range(0, 15));
      end else begin
        rp = $urandom_range(0, W - 1);
        ph = 4'b0001 << rp;
      end
      apply(($urandom_range(0, 199) == 0), ph, 8'($urandom),
            ($urandom_range(0, 2) != 0), ($urandom_range(0, 19) == 0));
      chk($sformatf("rand%0d", i), {m_bvalid, m_bword, m_err, m_ovr, m_cnt});
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
